// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: step count, opcodes, control-word
// bit positions and masks, and the run/halt state encoding.
package control_unit_pkg;

    // Micro-steps per instruction (T0..T4)
    localparam int NUM_STEPS_DEFAULT = 5;

    // Control word width
    localparam int CTRL_W = 16;

    // Control word bit positions, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    // Single-bit masks for building microcode words
    localparam logic [CTRL_W-1:0] CW_NONE = 16'h0000;
    localparam logic [CTRL_W-1:0] CW_HLT  = 16'h8000;
    localparam logic [CTRL_W-1:0] CW_MI   = 16'h4000;
    localparam logic [CTRL_W-1:0] CW_RI   = 16'h2000;
    localparam logic [CTRL_W-1:0] CW_RO   = 16'h1000;
    localparam logic [CTRL_W-1:0] CW_IO   = 16'h0800;
    localparam logic [CTRL_W-1:0] CW_II   = 16'h0400;
    localparam logic [CTRL_W-1:0] CW_AI   = 16'h0200;
    localparam logic [CTRL_W-1:0] CW_AO   = 16'h0100;
    localparam logic [CTRL_W-1:0] CW_EO   = 16'h0080;
    localparam logic [CTRL_W-1:0] CW_SU   = 16'h0040;
    localparam logic [CTRL_W-1:0] CW_BI   = 16'h0020;
    localparam logic [CTRL_W-1:0] CW_OI   = 16'h0010;
    localparam logic [CTRL_W-1:0] CW_CE   = 16'h0008;
    localparam logic [CTRL_W-1:0] CW_CO   = 16'h0004;
    localparam logic [CTRL_W-1:0] CW_J    = 16'h0002;
    localparam logic [CTRL_W-1:0] CW_FI   = 16'h0001;

    // Fetch words shared by every opcode
    localparam logic [CTRL_W-1:0] CW_FETCH_T0 = CW_CO | CW_MI;
    localparam logic [CTRL_W-1:0] CW_FETCH_T1 = CW_RO | CW_II | CW_CE;

    // Opcodes (upper nibble of the instruction); 0x0 and 0x9-0xD decode as NOP
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    // Sequencer run state: halt is sticky until reset
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    // Conditional jump bit: J only when the tested flag is set
    function automatic logic [CTRL_W-1:0] cond_jump(input logic flag);
        logic [CTRL_W-1:0] w;
        if (flag) begin
            w = CW_J;
        end else begin
            w = CW_NONE;
        end
        return w;
    endfunction

endpackage

// File: rtl/control_unit_microcode_rom.sv
// Microcode decode: maps (opcode, micro-step, C, Z) to the 16-bit control word.
// Purely combinational; halt override is applied by the top level.
module microcode_rom
    import control_unit_pkg::*;
(
    input  logic [3:0]        i_opcode,
    input  logic [2:0]        i_step,
    input  logic              i_c,
    input  logic              i_z,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [CTRL_W-1:0] w_exec;

    // Execute-phase word (T2..T4) per opcode; every other step decodes to zero
    always_comb begin
        w_exec = CW_NONE;
        case (opcode_t'(i_opcode))
            OP_LDA: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_MI;
                    3'd3:    w_exec = CW_RO | CW_AI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_ADD: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_MI;
                    3'd3:    w_exec = CW_RO | CW_BI;
                    3'd4:    w_exec = CW_EO | CW_AI | CW_FI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_SUB: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_MI;
                    3'd3:    w_exec = CW_RO | CW_BI;
                    3'd4:    w_exec = CW_EO | CW_AI | CW_SU | CW_FI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_STA: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_MI;
                    3'd3:    w_exec = CW_AO | CW_RI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_LDI: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_AI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_JMP: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | CW_J;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_JC: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | cond_jump(i_c);
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_JZ: begin
                case (i_step)
                    3'd2:    w_exec = CW_IO | cond_jump(i_z);
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_OUT: begin
                case (i_step)
                    3'd2:    w_exec = CW_AO | CW_OI;
                    default: w_exec = CW_NONE;
                endcase
            end
            OP_HLT: begin
                case (i_step)
                    3'd2:    w_exec = CW_HLT;
                    default: w_exec = CW_NONE;
                endcase
            end
            default: w_exec = CW_NONE;
        endcase
    end

    // Select the common fetch words for T0/T1, the execute word otherwise
    always_comb begin
        o_ctrl = CW_NONE;
        case (i_step)
            3'd0:    o_ctrl = CW_FETCH_T0;
            3'd1:    o_ctrl = CW_FETCH_T1;
            default: o_ctrl = w_exec;
        endcase
    end

endmodule

// File: rtl/tri_state_buffer.sv
// Generic tri-state bus driver: drives i_data onto io_bus while i_en is high,
// otherwise releases the bus to high-Z.
module tri_state_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    inout  wire  [WIDTH-1:0] io_bus
);

    assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/control_unit.sv
// Control unit top: micro-step sequencer, instruction register, C/Z flags,
// sticky halt, microcode decode and the IR-operand bus driver.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [7:0]        bus,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic [CTRL_W-1:0] ctrl,
    output logic              halted,
    output logic [2:0]        step,
    output logic [7:0]        ir
);

    // Last step index before the counter wraps back to T0
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    run_state_t        r_state;
    run_state_t        w_state_next;
    logic [2:0]        r_step;
    logic [7:0]        r_ir;
    logic              r_c;
    logic              r_z;
    logic              w_halted;
    logic [CTRL_W-1:0] w_rom_ctrl;
    logic              w_bus_en;
    logic [7:0]        w_bus_data;

    assign w_halted = (r_state == ST_HALT);

    microcode_rom u_microcode_rom (
        .i_opcode (r_ir[7:4]),
        .i_step   (r_step),
        .i_c      (r_c),
        .i_z      (r_z),
        .o_ctrl   (w_rom_ctrl)
    );

    // Control word: microcode decode, forced to HLT-only once halted
    always_comb begin
        ctrl = CW_NONE;
        if (w_halted) begin
            ctrl = CW_HLT;
        end else begin
            ctrl = w_rom_ctrl;
        end
    end

    // Run/halt next-state: any cycle with HLT active latches the halt
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (ctrl[B_HLT]) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_RUN;
        endcase
    end

    // Run/halt state register; only reset clears a halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step counter, IR and flags; all frozen while halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= 3'd0;
            r_ir   <= 8'h00;
            r_c    <= 1'b0;
            r_z    <= 1'b0;
        end else if (!w_halted) begin
            if (r_step == LAST_STEP) begin
                r_step <= 3'd0;
            end else begin
                r_step <= r_step + 3'd1;
            end
            if (ctrl[B_II]) begin
                r_ir <= bus;
            end
            if (ctrl[B_FI]) begin
                r_c <= carry_in;
                r_z <= zero_in;
            end
        end
    end

    // Operand nibble goes onto the bus only while IO is active
    assign w_bus_en   = ctrl[B_IO];
    assign w_bus_data = {4'b0000, r_ir[3:0]};

    tri_state_buffer #(
        .WIDTH (8)
    ) u_bus_driver (
        .i_en   (w_bus_en),
        .i_data (w_bus_data),
        .io_bus (bus)
    );

    assign halted = w_halted;
    assign step   = r_step;
    assign ir     = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a fixed vector table, hand-written
// flag/halt/reset sequences, and randomized instruction streams checked
// against a table-based behavioural model.
module tb_control_unit;

    localparam int         NUM_STEPS = 5;
    localparam logic [7:0] PROBE     = 8'hA0;

    localparam logic [15:0] K_HLT = 16'h8000, K_MI = 16'h4000, K_RI = 16'h2000, K_RO = 16'h1000;
    localparam logic [15:0] K_IO  = 16'h0800, K_II = 16'h0400, K_AI = 16'h0200, K_AO = 16'h0100;
    localparam logic [15:0] K_EO  = 16'h0080, K_SU = 16'h0040, K_BI = 16'h0020, K_OI = 16'h0010;
    localparam logic [15:0] K_CE  = 16'h0008, K_CO = 16'h0004, K_J  = 16'h0002, K_FI = 16'h0001;

    logic        clk;
    logic        rst;
    logic        carry_in;
    logic        zero_in;
    logic [15:0] ctrl;
    logic        halted;
    logic [2:0]  step;
    logic [7:0]  ir;
    wire  [7:0]  bus;
    logic        tb_bus_en;
    logic [7:0]  tb_bus_val;

    assign bus = tb_bus_en ? tb_bus_val : 8'hzz;

    control_unit #(.NUM_STEPS(NUM_STEPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .carry_in (carry_in),
        .zero_in  (zero_in),
        .ctrl     (ctrl),
        .halted   (halted),
        .step     (step),
        .ir       (ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    logic [15:0] ucode [16][NUM_STEPS];
    int          m_step;
    logic [7:0]  m_ir;
    logic        m_c, m_z, m_halted;
    logic [15:0] last_ctrl;
    logic [15:0] seen [NUM_STEPS];

    typedef struct {
        logic [7:0]  bus_in;
        logic [2:0]  exp_step;
        logic [15:0] exp_ctrl;
        logic [7:0]  exp_ir;
        logic [7:0]  exp_bus;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < NUM_STEPS; s++) ucode[o][s] = 16'h0000;
            ucode[o][0] = K_CO | K_MI;
            ucode[o][1] = K_RO | K_II | K_CE;
        end
        ucode[1][2] = K_IO | K_MI; ucode[1][3] = K_RO | K_AI;
        ucode[2][2] = K_IO | K_MI; ucode[2][3] = K_RO | K_BI; ucode[2][4] = K_EO | K_AI | K_FI;
        ucode[3][2] = K_IO | K_MI; ucode[3][3] = K_RO | K_BI; ucode[3][4] = K_EO | K_AI | K_FI | K_SU;
        ucode[4][2] = K_IO | K_MI; ucode[4][3] = K_AO | K_RI;
        ucode[5][2] = K_IO | K_AI;
        ucode[6][2] = K_IO | K_J;
        ucode[7][2] = K_IO;
        ucode[8][2] = K_IO;
        ucode[14][2] = K_AO | K_OI;
        ucode[15][2] = K_HLT;
    endtask

    task automatic model_reset();
        m_step = 0; m_ir = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halted = 1'b0;
    endtask

    function automatic logic [15:0] model_ctrl();
        logic [15:0] w;
        if (m_halted) return K_HLT;
        w = ucode[m_ir[7:4]][m_step];
        if (m_ir[7:4] == 4'h7 && m_step == 2 && m_c) w = w | K_J;
        if (m_ir[7:4] == 4'h8 && m_step == 2 && m_z) w = w | K_J;
        return w;
    endfunction

    // One clock cycle starting at a falling edge: drive, check, clock, update model
    task automatic cyc(input logic [7:0] instr, input logic cin, input logic zin);
        logic [15:0] exp_c;
        logic [7:0]  drv;
        exp_c    = model_ctrl();
        carry_in = cin;
        zero_in  = zin;
        drv      = (!m_halted && m_step == 1) ? instr : PROBE;
        if ((exp_c & K_IO) != 16'h0000) begin
            tb_bus_en = 1'b0;
        end else begin
            tb_bus_en  = 1'b1;
            tb_bus_val = drv;
        end
        #1;
        check("ctrl", ctrl, exp_c);
        check("step", 16'(step), 16'(m_step));
        check("ir", 16'(ir), 16'(m_ir));
        check("halted", 16'(halted), 16'(m_halted));
        if ((exp_c & K_IO) != 16'h0000) check("bus_drive", 16'(bus), {12'h000, m_ir[3:0]});
        else                            check("bus_release", 16'(bus), 16'(drv));
        last_ctrl = ctrl;
        @(posedge clk);
        if (!m_halted) begin
            if ((exp_c & K_II) != 16'h0000) m_ir = drv;
            if ((exp_c & K_FI) != 16'h0000) begin m_c = cin; m_z = zin; end
            if ((exp_c & K_HLT) != 16'h0000) m_halted = 1'b1;
            m_step = (m_step + 1) % NUM_STEPS;
        end
        @(negedge clk);
    endtask

    // One full instruction; cin4/zin4 are presented during T4
    task automatic run_instr(input logic [7:0] instr, input logic cin4, input logic zin4);
        for (int s = 0; s < NUM_STEPS; s++) begin
            if (s == 4) cyc(instr, cin4, zin4);
            else        cyc(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            seen[s] = last_ctrl;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tb_bus_en = 1'b1;
        tb_bus_val = PROBE;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        logic [7:0] instr;

        rst = 1'b1; carry_in = 1'b0; zero_in = 1'b0;
        tb_bus_en = 1'b1; tb_bus_val = PROBE;
        model_init();
        model_reset();

        // Reset state
        #1;
        check("rst_step", 16'(step), 16'h0000);
        check("rst_ir", 16'(ir), 16'h0000);
        check("rst_halted", 16'(halted), 16'h0000);
        check("rst_ctrl", ctrl, K_CO | K_MI);
        check("rst_bus", 16'(bus), 16'(PROBE));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fixed vector table: LDA 1E, NOP 9C, OUT E3, JMP 6A, LDI 5B
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'h00, 8'hA0});
        vecs.push_back('{8'h1E, 3'd1, 16'h1408, 8'h00, 8'h1E});
        vecs.push_back('{8'hA0, 3'd2, 16'h4800, 8'h1E, 8'h0E});
        vecs.push_back('{8'hA0, 3'd3, 16'h1200, 8'h1E, 8'hA0});
        vecs.push_back('{8'hA0, 3'd4, 16'h0000, 8'h1E, 8'hA0});
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'h1E, 8'hA0});
        vecs.push_back('{8'h9C, 3'd1, 16'h1408, 8'h1E, 8'h9C});
        vecs.push_back('{8'hA0, 3'd2, 16'h0000, 8'h9C, 8'hA0});
        vecs.push_back('{8'hA0, 3'd3, 16'h0000, 8'h9C, 8'hA0});
        vecs.push_back('{8'hA0, 3'd4, 16'h0000, 8'h9C, 8'hA0});
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'h9C, 8'hA0});
        vecs.push_back('{8'hE3, 3'd1, 16'h1408, 8'h9C, 8'hE3});
        vecs.push_back('{8'hA0, 3'd2, 16'h0110, 8'hE3, 8'hA0});
        vecs.push_back('{8'hA0, 3'd3, 16'h0000, 8'hE3, 8'hA0});
        vecs.push_back('{8'hA0, 3'd4, 16'h0000, 8'hE3, 8'hA0});
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'hE3, 8'hA0});
        vecs.push_back('{8'h6A, 3'd1, 16'h1408, 8'hE3, 8'h6A});
        vecs.push_back('{8'hA0, 3'd2, 16'h0802, 8'h6A, 8'h0A});
        vecs.push_back('{8'hA0, 3'd3, 16'h0000, 8'h6A, 8'hA0});
        vecs.push_back('{8'hA0, 3'd4, 16'h0000, 8'h6A, 8'hA0});
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'h6A, 8'hA0});
        vecs.push_back('{8'h5B, 3'd1, 16'h1408, 8'h6A, 8'h5B});
        vecs.push_back('{8'hA0, 3'd2, 16'h0A00, 8'h5B, 8'h0B});
        vecs.push_back('{8'hA0, 3'd3, 16'h0000, 8'h5B, 8'hA0});
        vecs.push_back('{8'hA0, 3'd4, 16'h0000, 8'h5B, 8'hA0});
        vecs.push_back('{8'hA0, 3'd0, 16'h4004, 8'h5B, 8'hA0});
        for (int i = 0; i < vecs.size(); i++) begin
            carry_in = 1'b0; zero_in = 1'b0;
            if ((vecs[i].exp_ctrl & K_IO) != 16'h0000) begin
                tb_bus_en = 1'b0;
            end else begin
                tb_bus_en = 1'b1;
                tb_bus_val = vecs[i].bus_in;
            end
            #1;
            check($sformatf("vec%0d_step", i), 16'(step), 16'(vecs[i].exp_step));
            check($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
            check($sformatf("vec%0d_ir", i), 16'(ir), 16'(vecs[i].exp_ir));
            check($sformatf("vec%0d_bus", i), 16'(bus), 16'(vecs[i].exp_bus));
            check($sformatf("vec%0d_halted", i), 16'(halted), 16'h0000);
            @(posedge clk);
            @(negedge clk);
        end

        // Flags from ADD/SUB T4 steer the following JC/JZ
        do_reset();
        run_instr(8'h23, 1'b1, 1'b0);
        check("add_t4", seen[4], K_EO | K_AI | K_FI);
        run_instr(8'h75, 1'b0, 1'b0);
        check("jc_taken", seen[2], K_IO | K_J);
        run_instr(8'h85, 1'b0, 1'b0);
        check("jz_not_taken", seen[2], K_IO);
        check("jz_not_t3", seen[3], 16'h0000);
        check("jz_not_t4", seen[4], 16'h0000);
        run_instr(8'h31, 1'b0, 1'b1);
        check("sub_t4", seen[4], K_EO | K_AI | K_FI | K_SU);
        run_instr(8'h72, 1'b0, 1'b0);
        check("jc_not_taken", seen[2], K_IO);
        check("jc_not_t4", seen[4], 16'h0000);
        run_instr(8'h84, 1'b0, 1'b0);
        check("jz_taken", seen[2], K_IO | K_J);
        check("wrap_after_jz", 16'(step), 16'h0000);

        // Asynchronous reset in T3 of an ADD aborts it and clears the flags
        run_instr(8'h2F, 1'b1, 1'b1);
        for (int s = 0; s < 3; s++) cyc(8'h21, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_step", 16'(step), 16'h0000);
        check("arst_ir", 16'(ir), 16'h0000);
        check("arst_halted", 16'(halted), 16'h0000);
        check("arst_ctrl", ctrl, K_CO | K_MI);
        @(negedge clk);
        #1;
        check("arst_hold_step", 16'(step), 16'h0000);
        rst = 1'b0;
        run_instr(8'h70, 1'b0, 1'b0);
        check("post_rst_t0", seen[0], K_CO | K_MI);
        check("post_rst_jc", seen[2], K_IO);
        run_instr(8'h80, 1'b0, 1'b0);
        check("post_rst_jz", seen[2], K_IO);

        // HLT at T2 latches halt and freezes everything
        do_reset();
        for (int s = 0; s < 3; s++) cyc(8'hF0, 1'b0, 1'b0);
        check("hlt_t2", last_ctrl, K_HLT);
        for (int k = 0; k < 20; k++) begin
            cyc(8'hF0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("halt_step", 16'(step), 16'h0003);
            check("halt_ctrl", last_ctrl, K_HLT);
            check("halt_flag", 16'(halted), 16'h0001);
            check("halt_ir", 16'(ir), 16'h00F0);
        end

        // Randomized instruction streams against the model
        do_reset();
        for (int n = 0; n < 250; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h3;
            instr = {op, 4'($urandom_range(0, 15))};
            run_instr(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (m_halted) begin
                for (int k = 0; k < 3; k++) cyc(instr, 1'b1, 1'b1);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
